mem_init_sequencer: RTL

- Per-clock-domain consumer of one bit each of TopLevelReset's sync_rst_out, init_out and clk_en_out.
- On an init request it sweeps a register file or RAM write port, writing a known value to every address, then raises init_done.
- After init_done it hands the write port to the functional client through a valid/ready handshake.
- Holds the client off during reset and sweep, so no stale memory contents survive a reset.

---
 rtl/mem_init_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_init_sequencer.sv
// Memory initialisation sequencer: sweeps a write port with a known word after init, then hands it to the client.
// Optional MEM_INIT_ADDR_PATTERN_EN: sweep data is the address zero-extended (memory self-test) instead of INITVALUE.
module mem_init_sequencer #(
  parameter int                   ADDRWIDTH = 8,
  parameter int                   DATAWIDTH = 32,
  parameter int                   DEPTH     = 256,
  parameter logic [DATAWIDTH-1:0] INITVALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 sync_rst,
  input  logic                 init,
  input  logic                 client_valid,
  input  logic [ADDRWIDTH-1:0] client_addr,
  input  logic [DATAWIDTH-1:0] client_data,
  output logic                 client_ready,
  output logic                 mem_wr_en,
  output logic [ADDRWIDTH-1:0] mem_wr_addr,
  output logic [DATAWIDTH-1:0] mem_wr_data,
  output logic                 busy,
  output logic                 init_done
);

  // One spare counter bit so DEPTH == 2**ADDRWIDTH reaches the terminal compare without wrapping.
  localparam int                  CNTWIDTH = ADDRWIDTH + 1;
  localparam logic [CNTWIDTH-1:0] LAST_CNT = CNTWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [CNTWIDTH-1:0]    cnt_reg;
  logic                   wr_en_reg;
  logic [ADDRWIDTH-1:0]   wr_addr_reg;
  logic [DATAWIDTH-1:0]   wr_data_reg;
  logic [DATAWIDTH-1:0]   sweep_data;

`ifdef MEM_INIT_ADDR_PATTERN_EN
  generate
    for (genvar gi = 0; gi < DATAWIDTH; gi++) begin : g_pattern
      if (gi < ADDRWIDTH) begin : g_addr_bit
        assign sweep_data[gi] = cnt_reg[gi];
      end else begin : g_zero_bit
        assign sweep_data[gi] = 1'b0;
      end
    end
  endgenerate
`else
  assign sweep_data = INITVALUE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else if (!clk_en) begin
      wr_en_reg <= 1'b0;
    end else if (sync_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      wr_en_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          wr_en_reg <= 1'b0;
          if (init) begin
            state_reg <= SWEEP;
            cnt_reg   <= '0;
          end
        end
        SWEEP: begin
          if (init) begin
            cnt_reg   <= '0;
            wr_en_reg <= 1'b0;
          end else begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= cnt_reg[ADDRWIDTH-1:0];
            wr_data_reg <= sweep_data;
            if (cnt_reg == LAST_CNT) begin
              state_reg <= DONE;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        DONE: begin
          if (init) begin
            state_reg <= SWEEP;
            cnt_reg   <= '0;
            wr_en_reg <= 1'b0;
          end else if (client_valid) begin
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= client_addr;
            wr_data_reg <= client_data;
          end else begin
            wr_en_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          wr_en_reg <= 1'b0;
        end
      endcase
    end
  end

  assign client_ready = (state_reg == DONE) && !sync_rst && !init;
  assign mem_wr_en    = wr_en_reg;
  assign mem_wr_addr  = wr_addr_reg;
  assign mem_wr_data  = wr_data_reg;
  assign busy         = (state_reg == SWEEP);
  assign init_done    = (state_reg == DONE);

endmodule
